fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-cache request, and holds the IF/ID pipeline latch that feeds decode.
- Consumes the hazard unit's stall/flush controls and the jump/branch redirect from later stages.
- Handles multi-cycle icache misses, including squashing a fetch that is still in flight when a redirect arrives.

Parameters:
PC_RESET, 32'h00000000, PC value loaded on reset
WORD_W, 32, instruction/address width (word_t)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, synchronous, active-high
pc_hold  in  1  hazard stall: freeze PC (hazard unit's pc_enable)
enable_ID  in  1  1 = IF/ID latch may load; 0 = hold contents
flush_ID  in  1  data-hazard bubble into IF/ID
flush_ID_j  in  1  jump-flush bubble into IF/ID
redirect_en  in  1  taken branch/jump/JR this cycle
redirect_pc  in  32  redirect target
halt_req  in  1  HALT decoded; stop fetching
ihit  in  1  icache returns data this cycle
iload  in  32  icache read data
iREN  out  1  icache read request
iaddr  out  32  icache request address
instr_ID  out  32  IF/ID instruction
npc_ID  out  32  IF/ID PC+4 of that instruction
valid_ID  out  1  IF/ID holds a real instruction
halted  out  1  fetch stopped

Behaviour:
- Reset (RST high at an edge):
  - pc=PC_RESET, state=RUN.
  - instr_ID=0, npc_ID=0, valid_ID=0, halted=0.
  - iREN=0 combinationally while RST is high.
- States:
  - RUN: iREN=1, iaddr=pc.
  - DRAIN: iREN=1, iaddr=drain_addr. Waits for a stale miss to finish.
  - HALTED: iREN=0.
- Priority at each edge: RST > halt_req > redirect_en > flush_ID|flush_ID_j > pc_hold/enable_ID.
- RUN, normal fetch (ihit=1, pc_hold=0, enable_ID=1):
  - pc <= pc+4.
  - IF/ID <= {iload, pc+4, 1}.
  - Steady-state latency is 1 cycle from ihit to instr_ID.
- RUN, ihit=1 with pc_hold=1 or enable_ID=0:
  - pc and IF/ID unchanged; the returned data is dropped.
  - Request repeats next cycle; the cache re-hits.
- RUN, ihit=0 with enable_ID=1 and pc_hold=0: IF/ID <= bubble {0,0,0}; pc unchanged.
- RUN, ihit=0 with enable_ID=0: IF/ID holds.
- flush_ID or flush_ID_j:
  - IF/ID <= bubble regardless of enable_ID.
  - pc still advances if the normal-fetch condition holds.
- redirect_en:
  - pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble.
  - In RUN with ihit=0: drain_addr <= old pc, go to DRAIN.
  - In RUN with ihit=1: go directly to RUN at the target; returned data is discarded.
  - In DRAIN: only pc is updated; drain_addr is unchanged.
- DRAIN:
  - Every cycle IF/ID <= bubble unless enable_ID=0.
  - On ihit: data discarded, go to RUN next cycle at the current pc.
  - DRAIN never loads IF/ID with valid data.
- halt_req:
  - Go to HALTED; halted=1; IF/ID <= bubble.
  - Sticky until RST; later redirects are ignored.
  - If a miss is outstanding, first DRAIN to completion with halt pending, then HALTED.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0. pc[1:0] is always 00.
- RST mid-miss: the outstanding request is abandoned and iREN drops immediately. The cache must tolerate this.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0 and wrapping at 2^32:
  - fetch_cnt: +1 per IF/ID load with valid=1.
  - bubble_cnt: +1 per edge where IF/ID loads a bubble.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
1. RST 1 cycle, ihit=1 always, iload=pc-tagged, no stalls -> iaddr 0,4,8; instr_ID valid every cycle; npc_ID=4,8,12.
2. ihit low for 3 cycles at pc=0x10 -> 3 bubbles (valid_ID=0); pc stays 0x10; then instr_ID=mem[0x10], npc_ID=0x14.
3. pc_hold=1 and enable_ID=0 for 2 cycles with ihit=1 at pc=0x20 -> pc, instr_ID, npc_ID frozen; resume yields next fetch at 0x24.
4. Miss at pc=0x40, then redirect_en with redirect_pc=0x103 -> iaddr stays 0x40 until ihit; that data is dropped, never valid in IF/ID; next iaddr=0x100.
5. Same-cycle ihit + redirect_en to 0x200 -> no DRAIN; next iaddr=0x200; IF/ID bubble. flush_ID_j with enable_ID=0 -> IF/ID cleared.
6. halt_req during a miss -> DRAIN, then halted=1, iREN=0; redirects ignored. Reset with pc=0xFFFFFFFC fetch -> pc wraps to 0. With FETCH_STATS_EN, counters match the valid/bubble counts.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline.
// Owns the PC, issues icache read requests, and holds the IF/ID latch
// that feeds decode. The stall and flush controls come from the hazard
// unit, and redirects come from later stages. A miss that is still in
// flight when a redirect or halt arrives is drained. Its data is dropped.
// Optional build macro: FETCH_STATS_EN adds the fetch_cnt and bubble_cnt
// outputs.
module fetch_stage #(
  parameter int                 WORD_W   = 32,
  parameter logic [WORD_W-1:0]  PC_RESET = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pc_hold,
  input  logic              enable_ID,
  input  logic              flush_ID,
  input  logic              flush_ID_j,
  input  logic              redirect_en,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] instr_ID,
  output logic [WORD_W-1:0] npc_ID,
  output logic              valid_ID,
  output logic              halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] drain_addr;
  logic              halt_pend;

  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] redirect_tgt;
  logic              flush_any;
  logic              fetch_go;
  logic              ld_valid;
  logic              ld_bubble;

  // Redirect targets are word addresses; the low two bits are discarded.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Word-aligned PC increment, wrapping modulo 2^WORD_W.
  function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] a);
    return a + WORD_W'(4);
  endfunction

  // Force a target onto a word boundary.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

  assign pc_plus4     = next_word(pc);
  assign redirect_tgt = word_align(redirect_pc);
  assign flush_any    = flush_ID | flush_ID_j;

  // Cache request: the PC while running, the stale miss address while draining.
  always_comb begin
    iREN  = 1'b0;
    iaddr = pc;
    if (!RST) begin
      case (state)
        S_RUN:   iREN = 1'b1;
        S_DRAIN: begin
          iREN  = 1'b1;
          iaddr = drain_addr;
        end
        default: iREN = 1'b0;
      endcase
    end
  end

  // Decide what the IF/ID latch takes this edge: a real instruction, a bubble, or hold.
  always_comb begin
    fetch_go  = 1'b0;
    ld_valid  = 1'b0;
    ld_bubble = 1'b0;
    if (!RST) begin
      case (state)
        S_RUN: begin
          fetch_go = !halt_req && !redirect_en && ihit && !pc_hold && enable_ID;
          if (halt_req || redirect_en || flush_any) begin
            ld_bubble = 1'b1;
          end else if (enable_ID) begin
            if (!ihit) begin
              ld_bubble = 1'b1;
            end else if (!pc_hold) begin
              ld_valid = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // A stale response never enters decode.
          ld_bubble = halt_req || redirect_en || flush_any || enable_ID;
        end
        default: begin
          fetch_go  = 1'b0;
          ld_valid  = 1'b0;
          ld_bubble = 1'b0;
        end
      endcase
    end
  end

  // Fetch FSM: PC, drain bookkeeping and the sticky halt.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_RUN;
      pc         <= PC_RESET;
      drain_addr <= PC_RESET;
      halt_pend  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (halt_req) begin
            if (ihit) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state      <= S_DRAIN;
              drain_addr <= pc;
              halt_pend  <= 1'b1;
            end
          end else if (redirect_en) begin
            pc <= redirect_tgt;
            if (!ihit) begin
              state      <= S_DRAIN;
              drain_addr <= pc;
            end
          end else if (fetch_go) begin
            pc <= pc_plus4;
          end
        end
        S_DRAIN: begin
          if (halt_req) begin
            halt_pend <= 1'b1;
          end else if (redirect_en && !halt_pend) begin
            pc <= redirect_tgt;
          end
          if (ihit) begin
            if (halt_pend || halt_req) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        default: begin
          state <= S_HALTED;
        end
      endcase
    end
  end

  // ---- IF/ID pipeline boundary ----
  // Load a fetched instruction or a bubble; otherwise hold for decode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_ID <= '0;
      npc_ID   <= '0;
      valid_ID <= 1'b0;
    end else if (ld_valid) begin
      instr_ID <= iload;
      npc_ID   <= pc_plus4;
      valid_ID <= 1'b1;
    end else if (ld_bubble) begin
      instr_ID <= '0;
      npc_ID   <= '0;
      valid_ID <= 1'b0;
    end
  end

`ifdef FETCH_STATS_EN
  // Count valid loads and bubble loads of the IF/ID latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (ld_valid)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (ld_bubble) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run
// against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST, pc_hold, enable_ID, flush_ID, flush_ID_j;
  logic        redirect_en, halt_req, ihit;
  logic [31:0] redirect_pc, iload;
  logic        iREN, valid_ID, halted;
  logic [31:0] iaddr, instr_ID, npc_ID;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.WORD_W(32), .PC_RESET(32'h0)) dut (
    .CLK(CLK), .RST(RST), .pc_hold(pc_hold), .enable_ID(enable_ID),
    .flush_ID(flush_ID), .flush_ID_j(flush_ID_j), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .ihit(ihit), .iload(iload),
    .iREN(iREN), .iaddr(iaddr), .instr_ID(instr_ID), .npc_ID(npc_ID),
    .valid_ID(valid_ID), .halted(halted)
`ifdef FETCH_STATS_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory contents are tagged with their own address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  assign iload = word_at(iaddr);

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_req, m_instr, m_npc, m_fetches, m_bubbles;
  bit          m_draining, m_stopped, m_halt_wanted, m_valid, m_halted;

  function automatic bit exp_iren();
    return !RST && !m_stopped;
  endfunction

  function automatic logic [31:0] exp_iaddr();
    return m_draining ? m_req : m_pc;
  endfunction

  // Apply the fetch rules for one rising edge, using the inputs now applied.
  task automatic model_edge();
    logic [31:0] tgt;
    logic [31:0] old_pc;
    bit flush, take_valid, take_bubble, fetch;
    tgt = {redirect_pc[31:2], 2'b00};
    old_pc = m_pc;
    flush = flush_ID || flush_ID_j;
    take_valid = 0;
    take_bubble = 0;
    if (RST) begin
      m_pc = 32'h0; m_req = 32'h0; m_draining = 0; m_stopped = 0;
      m_halt_wanted = 0; m_instr = 0; m_npc = 0; m_valid = 0; m_halted = 0;
      m_fetches = 0; m_bubbles = 0;
      return;
    end
    if (m_stopped) return;
    if (m_draining) begin
      if (halt_req) m_halt_wanted = 1;
      else if (redirect_en && !m_halt_wanted) m_pc = tgt;
      take_bubble = halt_req || redirect_en || flush || enable_ID;
      if (ihit) begin
        m_draining = 0;
        if (m_halt_wanted) begin m_stopped = 1; m_halted = 1; end
      end
    end else if (halt_req) begin
      take_bubble = 1;
      if (ihit) begin m_stopped = 1; m_halted = 1; end
      else begin m_draining = 1; m_req = old_pc; m_halt_wanted = 1; end
    end else if (redirect_en) begin
      take_bubble = 1;
      if (!ihit) begin m_draining = 1; m_req = old_pc; end
      m_pc = tgt;
    end else begin
      fetch = ihit && !pc_hold && enable_ID;
      if (flush) take_bubble = 1;
      else if (fetch) take_valid = 1;
      else if (enable_ID && !ihit) take_bubble = 1;
      if (fetch) m_pc = old_pc + 32'd4;
    end
    if (take_valid) begin
      m_instr = word_at(old_pc); m_npc = old_pc + 32'd4; m_valid = 1;
      m_fetches = m_fetches + 1;
    end else if (take_bubble) begin
      m_instr = 0; m_npc = 0; m_valid = 0;
      m_bubbles = m_bubbles + 1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic set_idle();
    RST = 0; pc_hold = 0; enable_ID = 1; flush_ID = 0; flush_ID_j = 0;
    redirect_en = 0; redirect_pc = 0; halt_req = 0; ihit = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    RST = 1;
    tick(); tick();
    checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL reset_iren got=%0b exp=0", iREN); end
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_ID); end
    checks++; if (instr_ID !== 32'h0 || npc_ID !== 32'h0) begin failures++; $display("FAIL reset_ifid got=%h/%h exp=0/0", instr_ID, npc_ID); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    RST = 0; #1;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h0) begin failures++; $display("FAIL reset_first_req got=%0b/%h exp=1/0", iREN, iaddr); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (iaddr !== 32'(4 * (i + 1)) || npc_ID !== 32'(4 * (i + 1)) ||
          instr_ID !== word_at(32'(4 * i)) || valid_ID !== 1'b1) begin
        failures++;
        $display("FAIL seq_fetch%0d got=%h/%h/%h/%0b exp=%h/%h/%h/1", i, iaddr, npc_ID, instr_ID,
                 valid_ID, 32'(4 * (i + 1)), 32'(4 * (i + 1)), word_at(32'(4 * i)));
      end
    end
  endtask

  task automatic test_miss();
    tick();
    ihit = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid_ID !== 1'b0 || iaddr !== 32'h10) begin
        failures++; $display("FAIL miss_bubble%0d got=%0b/%h exp=0/00000010", i, valid_ID, iaddr);
      end
    end
    ihit = 1;
    tick();
    checks++;
    if (instr_ID !== word_at(32'h10) || npc_ID !== 32'h14 || valid_ID !== 1'b1) begin
      failures++; $display("FAIL miss_return got=%h/%h/%0b exp=%h/00000014/1", instr_ID, npc_ID, valid_ID, word_at(32'h10));
    end
  endtask

  task automatic test_stall();
    redirect_en = 1; redirect_pc = 32'h1C; tick(); redirect_en = 0;
    checks++; if (iaddr !== 32'h1C || valid_ID !== 1'b0) begin failures++; $display("FAIL stall_redirect got=%h/%0b exp=0000001c/0", iaddr, valid_ID); end
    tick();
    pc_hold = 1; enable_ID = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (iaddr !== 32'h20 || npc_ID !== 32'h20 || instr_ID !== word_at(32'h1C) || valid_ID !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d got=%h/%h/%h/%0b exp=00000020/00000020/%h/1", i, iaddr, npc_ID, instr_ID, valid_ID, word_at(32'h1C));
      end
    end
    pc_hold = 0; enable_ID = 1;
    tick();
    checks++;
    if (instr_ID !== word_at(32'h20) || npc_ID !== 32'h24 || iaddr !== 32'h24) begin
      failures++; $display("FAIL stall_resume got=%h/%h/%h exp=%h/00000024/00000024", instr_ID, npc_ID, iaddr, word_at(32'h20));
    end
  endtask

  task automatic test_drain();
    redirect_en = 1; redirect_pc = 32'h3C; tick(); redirect_en = 0;
    tick();
    ihit = 0; tick();
    redirect_en = 1; redirect_pc = 32'h103; tick(); redirect_en = 0;
    tick();
    checks++; if (iaddr !== 32'h40 || iREN !== 1'b1 || valid_ID !== 1'b0) begin failures++; $display("FAIL drain_addr got=%h/%0b/%0b exp=00000040/1/0", iaddr, iREN, valid_ID); end
    ihit = 1; tick();
    checks++; if (valid_ID !== 1'b0 || iaddr !== 32'h100) begin failures++; $display("FAIL drain_drop got=%0b/%h exp=0/00000100", valid_ID, iaddr); end
    tick();
    checks++; if (instr_ID !== word_at(32'h100) || npc_ID !== 32'h104 || valid_ID !== 1'b1) begin failures++; $display("FAIL drain_target got=%h/%h/%0b exp=%h/00000104/1", instr_ID, npc_ID, valid_ID, word_at(32'h100)); end
  endtask

  task automatic test_redirect_hit();
    redirect_en = 1; redirect_pc = 32'h200; tick(); redirect_en = 0;
    checks++; if (iaddr !== 32'h200 || valid_ID !== 1'b0 || iREN !== 1'b1) begin failures++; $display("FAIL hitredir got=%h/%0b exp=00000200/0", iaddr, valid_ID); end
    tick();
    checks++; if (valid_ID !== 1'b1 || npc_ID !== 32'h204) begin failures++; $display("FAIL hitredir_fetch got=%0b/%h exp=1/00000204", valid_ID, npc_ID); end
    flush_ID_j = 1; enable_ID = 0; ihit = 0; tick();
    flush_ID_j = 0; enable_ID = 1; ihit = 1;
    checks++; if (valid_ID !== 1'b0 || instr_ID !== 32'h0 || npc_ID !== 32'h0 || iaddr !== 32'h204) begin failures++; $display("FAIL flushj got=%0b/%h/%h/%h exp=0/0/0/00000204", valid_ID, instr_ID, npc_ID, iaddr); end
  endtask

  task automatic test_wrap();
    redirect_en = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_en = 0;
    tick();
    checks++; if (npc_ID !== 32'h0 || iaddr !== 32'h0 || instr_ID !== word_at(32'hFFFF_FFFC) || valid_ID !== 1'b1) begin failures++; $display("FAIL wrap got=%h/%h/%h exp=0/0/%h", npc_ID, iaddr, instr_ID, word_at(32'hFFFF_FFFC)); end
  endtask

  task automatic test_halt();
    ihit = 0; tick();
    halt_req = 1; tick(); halt_req = 0;
    checks++; if (halted !== 1'b0 || iREN !== 1'b1 || iaddr !== 32'h0) begin failures++; $display("FAIL halt_drain got=%0b/%0b/%h exp=0/1/0", halted, iREN, iaddr); end
    redirect_en = 1; redirect_pc = 32'h300; tick();
    checks++; if (halted !== 1'b0 || iREN !== 1'b1 || valid_ID !== 1'b0) begin failures++; $display("FAIL halt_pending got=%0b/%0b/%0b exp=0/1/0", halted, iREN, valid_ID); end
    ihit = 1; tick();
    checks++; if (halted !== 1'b1 || iREN !== 1'b0 || valid_ID !== 1'b0) begin failures++; $display("FAIL halt_enter got=%0b/%0b/%0b exp=1/0/0", halted, iREN, valid_ID); end
    tick(); tick();
    redirect_en = 0;
    checks++; if (halted !== 1'b1 || iREN !== 1'b0) begin failures++; $display("FAIL halt_sticky got=%0b/%0b exp=1/0", halted, iREN); end
    RST = 1; tick(); RST = 0; #1;
    checks++; if (halted !== 1'b0 || iREN !== 1'b1 || iaddr !== 32'h0) begin failures++; $display("FAIL halt_reset got=%0b/%0b/%h exp=0/1/0", halted, iREN, iaddr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      RST         = ($urandom % 250) == 0;
      halt_req    = ($urandom % 400) == 0;
      redirect_en = ($urandom % 12) == 0;
      redirect_pc = $urandom;
      ihit        = ($urandom % 4) != 0;
      pc_hold     = ($urandom % 8) == 0;
      enable_ID   = ($urandom % 7) != 0;
      flush_ID    = ($urandom % 16) == 0;
      flush_ID_j  = ($urandom % 20) == 0;
      #1;
      checks++;
      if (iREN !== exp_iren() || (exp_iren() && iaddr !== exp_iaddr())) begin
        failures++; $display("FAIL rand_req cyc=%0d got=%0b/%h exp=%0b/%h", n, iREN, iaddr, exp_iren(), exp_iaddr());
      end
      tick();
      checks++;
      if (instr_ID !== m_instr || npc_ID !== m_npc || valid_ID !== m_valid || halted !== m_halted) begin
        failures++; $display("FAIL rand_ifid cyc=%0d got=%h/%h/%0b/%0b exp=%h/%h/%0b/%0b", n,
                             instr_ID, npc_ID, valid_ID, halted, m_instr, m_npc, m_valid, m_halted);
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (fetch_cnt !== m_fetches || bubble_cnt !== m_bubbles) begin
        failures++; $display("FAIL rand_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", n, fetch_cnt, bubble_cnt, m_fetches, m_bubbles);
      end
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    RST = 1;
    test_reset();
    test_sequential();
    test_miss();
    test_stall();
    test_drain();
    test_redirect_hit();
    test_wrap();
    test_halt();
    set_idle();
    RST = 1; tick(); RST = 0;
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
